// File: rtl/q2_sequencer_if.sv
// Bus between the q2 sequencer and its environment: opcode bits and
// front-panel switches in, machine-state bits and status out.
interface q2_sequencer_if;
    logic op2;
    logic op3;
    logic op4;
    logic op5;
    logic run_sw;
    logic step_sw;
    logic halt;
    logic s0;
    logic s1;
    logic s2;
    logic s3;
    logic ws;
    logic running;
    logic boundary;

    // Environment side: drives opcode/switches, observes state.
    modport master (
        output op2, op3, op4, op5, run_sw, step_sw, halt,
        input  s0, s1, s2, s3, ws, running, boundary
    );

    // Sequencer side.
    modport slave (
        input  op2, op3, op4, op5, run_sw, step_sw, halt,
        output s0, s1, s2, s3, ws, running, boundary
    );
endinterface

// File: rtl/q2_sequencer.sv
// q2 machine-state sequencer: steps each instruction through
// FETCH/LOAD/DEREF/EXEC/ALU_k, two clocks per state (settle, write), with
// front-panel run/step/halt control applied only at instruction boundaries.
module q2_sequencer #(
    parameter int ALU_STEPS     = 8,
    parameter bit START_RUNNING = 1'b0
) (
    input logic           clk,
    input logic           rst,
    q2_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        ST_FETCH = 4'd0,  ST_LOAD  = 4'd1,  ST_DEREF = 4'd2,  ST_EXEC  = 4'd3,
        ST_ALU0  = 4'd4,  ST_ALU1  = 4'd5,  ST_ALU2  = 4'd6,  ST_ALU3  = 4'd7,
        ST_ALU4  = 4'd8,  ST_ALU5  = 4'd9,  ST_ALU6  = 4'd10, ST_ALU7  = 4'd11,
        ST_ALU8  = 4'd12, ST_ALU9  = 4'd13, ST_ALU10 = 4'd14, ST_ALU11 = 4'd15
    } state_e;

    localparam logic [3:0] LAST_ALU = 4'(3 + ALU_STEPS);

    state_e r_state;
    logic   r_ws;
    logic   r_running;
    logic   r_boundary;
    logic   r_step_pending;
    logic   r_step_q;

    state_e w_state_nx;
    state_e w_succ;
    logic   w_ws_nx;
    logic   w_run_nx;
    logic   w_bnd_nx;
    logic   w_pend_nx;
    logic   w_step_edge;
    logic   w_alu_op;
    logic   w_stopped;
    logic   w_illegal;

    assign w_step_edge = bus.step_sw & ~r_step_q;
    assign w_alu_op    = ~bus.op5 | (~bus.op3 & ~bus.op4);
    assign w_stopped   = (r_state == ST_FETCH) & ~r_ws & ~r_running;
    assign w_illegal   = (r_state > LAST_ALU);

    // State register; the step_sw edge detector is reloaded on reset so a
    // switch already held high does not look like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_FETCH;
            r_ws           <= 1'b0;
            r_running      <= START_RUNNING;
            r_boundary     <= 1'b0;
            r_step_pending <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_ws           <= w_ws_nx;
            r_running      <= w_run_nx;
            r_boundary     <= w_bnd_nx;
            r_step_pending <= w_pend_nx;
        end
        r_step_q <= bus.step_sw;
    end

    // Successor state, used only at the end of a write phase.
    always_comb begin
        w_succ = ST_FETCH;
        case (r_state)
            ST_FETCH: w_succ = ST_LOAD;
            ST_LOAD:  w_succ = bus.op2 ? ST_DEREF : ST_EXEC;
            ST_DEREF: w_succ = ST_EXEC;
            ST_EXEC:  w_succ = w_alu_op ? ST_ALU0 : ST_FETCH;
            default:  w_succ = (r_state == state_e'(LAST_ALU)) ? ST_FETCH
                                                                : state_e'(r_state + 4'd1);
        endcase
    end

    // Next-state/outputs: phase toggling, start from stopped, and the
    // stop decision made on each entry to FETCH phase 0.
    always_comb begin
        w_state_nx = r_state;
        w_ws_nx    = r_ws;
        w_run_nx   = r_running;
        w_bnd_nx   = 1'b0;
        w_pend_nx  = r_step_pending;
        if (w_illegal) begin
            w_state_nx = ST_FETCH;
            w_ws_nx    = 1'b0;
        end else if (w_stopped) begin
            // The stopped clock doubles as FETCH phase 0 of the new instruction.
            if (bus.run_sw && !bus.halt) begin
                w_run_nx  = 1'b1;
                w_ws_nx   = 1'b1;
                w_pend_nx = 1'b0;
            end else if (w_step_edge && !bus.halt) begin
                w_run_nx  = 1'b1;
                w_ws_nx   = 1'b1;
                w_pend_nx = 1'b1;
            end
        end else if (!r_ws) begin
            w_ws_nx = 1'b1;
        end else begin
            w_ws_nx    = 1'b0;
            w_state_nx = w_succ;
            if (w_succ == ST_FETCH) begin
                w_bnd_nx = 1'b1;
                if (bus.halt) begin
                    w_run_nx  = 1'b0;
                    w_pend_nx = 1'b0;
                end else if (bus.run_sw && !r_step_pending) begin
                    w_run_nx = 1'b1;
                end else if (w_step_edge) begin
                    w_run_nx  = 1'b1;
                    w_pend_nx = 1'b1;
                end else begin
                    w_run_nx  = 1'b0;
                    w_pend_nx = 1'b0;
                end
            end
        end
    end

    assign {bus.s3, bus.s2, bus.s1, bus.s0} = r_state;
    assign bus.ws       = r_ws;
    assign bus.running  = r_running;
    assign bus.boundary = r_boundary;

endmodule
